// File: rtl/alarm_pio_pkg.sv
// Shared constants for the alarm-clock PIO blocks:
// bus geometry, register word addresses and edge-type encodings.
package alarm_pio_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/alarm_button_pio_in_if.sv
// Avalon-MM slave bus bundle for the alarm PIOs:
// 2-bit word address, 32-bit data, zero wait states.
interface alarm_button_pio_in_if;
    import alarm_pio_pkg::*;

    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/alarm_btn_debounce.sv
// One input pin: multi-flop synchroniser, then a hold counter
// that only accepts a level that persists for DEBOUNCE_CYCLES.
module alarm_btn_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic stable_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync_w;

    assign sync_w   = sync_q[SYNC_STAGES-1];
    assign stable_o = stable_q;

    // Shift the raw pin through the synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    // Count while the synced level differs; accept it on the last count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_w != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_w;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Debounce counter and accepted level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= IDLE_LEVEL;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/alarm_button_pio_in.sv
// Input PIO for alarm-clock buttons/switches: debounced data,
// sticky edge capture with W1C, maskable level interrupt.
module alarm_button_pio_in
    import alarm_pio_pkg::*;
#(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   SYNC_STAGES     = 2,
    parameter int   EDGE_TYPE       = 1,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alarm_button_pio_in_if.slave avs,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0] stable_w;
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr_w;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             wr_w;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        alarm_btn_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .pin_i    (in_port[i]),
            .stable_o (stable_w[i])
        );
    end

    assign wr_w         = avs.chipselect & ~avs.write_n;
    assign unused_wdata = ^avs.writedata;

    // Delayed copy of the debounced state for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_dly_q <= {WIDTH{IDLE_LEVEL}};
        end else begin
            stable_dly_q <= stable_w;
        end
    end

    // Select which transitions count as events.
    always_comb begin
        edge_hit = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_hit = stable_w & ~stable_dly_q;
            EDGE_FALL: edge_hit = ~stable_w & stable_dly_q;
            default:   edge_hit = stable_w ^ stable_dly_q;
        endcase
    end

    // Register writes; a new edge beats a coincident clear.
    always_comb begin
        mask_d = mask_q;
        clr_w  = '0;
        if (wr_w && avs.address == PIO_ADDR_IRQMASK) begin
            mask_d = avs.writedata[WIDTH-1:0];
        end
        if (wr_w && avs.address == PIO_ADDR_EDGECAP) begin
            clr_w = avs.writedata[WIDTH-1:0];
        end
        cap_d = (cap_q & ~clr_w) | edge_hit;
    end

    // Interrupt mask and edge-capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            PIO_ADDR_DATA:    avs.readdata = DATA_W'(stable_w);
            PIO_ADDR_IRQMASK: avs.readdata = DATA_W'(mask_q);
            PIO_ADDR_EDGECAP: avs.readdata = DATA_W'(cap_q);
            default:          avs.readdata = '0;
        endcase
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_alarm_button_pio_in.sv
// Bench for alarm_button_pio_in: falling-edge and any-edge builds,
// reads scored against a queue of expected data/irq values.
module tb_alarm_button_pio_in;

    logic       clk;
    logic       reset_n;
    logic [3:0] in0;
    logic [3:0] in1;
    logic       irq0;
    logic       irq1;
    logic       rd_strobe;

    int vectors;
    int miscompares;

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        irq;
        string       name;
    } exp_t;

    exp_t sb[$];

    alarm_button_pio_in_if if0 ();
    alarm_button_pio_in_if if1 ();

    alarm_button_pio_in #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2),
        .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .avs(if0),
        .in_port(in0), .irq(irq0)
    );

    alarm_button_pio_in #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2),
        .EDGE_TYPE(2), .IDLE_LEVEL(1'b1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .avs(if1),
        .in_port(in1), .irq(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pop expected response whenever a read is presented.
    always @(negedge clk) begin
        if (rd_strobe) begin
            exp_t        e;
            logic [31:0] got;
            logic        gi;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_empty: read with no expected entry");
            end else begin
                e   = sb.pop_front();
                got = (e.dut == 0) ? if0.readdata : if1.readdata;
                gi  = (e.dut == 0) ? irq0 : irq1;
                vectors++;
                if (got !== e.data) begin
                    miscompares++;
                    $display("FAIL %s data: got %h want %h",
                             e.name, got, e.data);
                end
                vectors++;
                if (gi !== e.irq) begin
                    miscompares++;
                    $display("FAIL %s irq: got %b want %b",
                             e.name, gi, e.irq);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if0.chipselect = 1'b0; if0.write_n = 1'b1;
        if0.address = 2'd0;    if0.writedata = '0;
        if1.chipselect = 1'b0; if1.write_n = 1'b1;
        if1.address = 2'd0;    if1.writedata = '0;
    endtask

    task automatic wr(input int d, input logic [1:0] a,
                      input logic [31:0] v);
        if (d == 0) begin
            if0.address = a; if0.writedata = v;
            if0.chipselect = 1'b1; if0.write_n = 1'b0;
        end else begin
            if1.address = a; if1.writedata = v;
            if1.chipselect = 1'b1; if1.write_n = 1'b0;
        end
        tick(1);
        idle();
    endtask

    task automatic rd(input int d, input logic [1:0] a,
                      input logic [31:0] v, input logic ei,
                      input string nm);
        exp_t e;
        e.dut = d; e.data = v; e.irq = ei; e.name = nm;
        sb.push_back(e);
        if (d == 0) begin
            if0.address = a; if0.chipselect = 1'b1; if0.write_n = 1'b1;
        end else begin
            if1.address = a; if1.chipselect = 1'b1; if1.write_n = 1'b1;
        end
        rd_strobe = 1'b1;
        tick(1);
        rd_strobe = 1'b0;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rd_strobe   = 1'b0;
        reset_n     = 1'b0;
        in0         = 4'hF;
        in1         = 4'hF;
        idle();
        tick(3);
        reset_n = 1'b1;

        // reset mid-count, pins back at idle during reset
        in0 = 4'hE;
        tick(3);
        reset_n = 1'b0;
        in0 = 4'hF;
        tick(2);
        reset_n = 1'b1;
        rd(0, 2'd0, 32'hF, 1'b0, "rst_data");
        rd(0, 2'd2, 32'h0, 1'b0, "rst_mask");
        rd(0, 2'd3, 32'h0, 1'b0, "rst_cap");
        tick(20);
        rd(0, 2'd3, 32'h0, 1'b0, "rst_cap_20");
        rd(0, 2'd0, 32'hF, 1'b0, "rst_data_20");

        // clean press on bit 1, exact latency
        wr(0, 2'd2, 32'h2);
        in0 = 4'hD;
        rd(0, 2'd0, 32'hF, 1'b0, "press_t0");
        tick(3);
        rd(0, 2'd0, 32'hF, 1'b0, "press_t4");
        rd(0, 2'd0, 32'hF, 1'b0, "press_t5");
        rd(0, 2'd0, 32'hD, 1'b0, "press_t6");
        rd(0, 2'd3, 32'h2, 1'b1, "press_cap_t7");

        // clear / mask / ignored writes
        wr(0, 2'd3, 32'h0);
        rd(0, 2'd3, 32'h2, 1'b1, "w1c_zero");
        wr(0, 2'd0, 32'hFFFF_FFFF);
        wr(0, 2'd1, 32'hFFFF_FFFF);
        rd(0, 2'd0, 32'hD, 1'b1, "data_ro");
        rd(0, 2'd1, 32'h0, 1'b1, "rsvd");
        rd(0, 2'd2, 32'h2, 1'b1, "mask_rd");
        wr(0, 2'd2, 32'hFFFF_FFF0);
        rd(0, 2'd3, 32'h2, 1'b0, "mask_off");
        wr(0, 2'd2, 32'h2);
        wr(0, 2'd3, 32'h2);
        rd(0, 2'd3, 32'h0, 1'b0, "w1c_bit1");

        // release (rising, not captured), then set/clear collision
        in0 = 4'hF;
        tick(10);
        rd(0, 2'd0, 32'hF, 1'b0, "release");
        rd(0, 2'd3, 32'h0, 1'b0, "rise_ignored");
        in0 = 4'hD;
        tick(6);
        wr(0, 2'd3, 32'h2);
        rd(0, 2'd3, 32'h2, 1'b1, "set_beats_clr");
        wr(0, 2'd3, 32'hF);
        rd(0, 2'd3, 32'h0, 1'b0, "clr_after");

        // glitch rejection on bit 2
        wr(0, 2'd2, 32'h4);
        in0 = 4'h9;
        tick(3);
        in0 = 4'hD;
        tick(10);
        rd(0, 2'd0, 32'hD, 1'b0, "glitch3_data");
        rd(0, 2'd3, 32'h0, 1'b0, "glitch3_cap");
        in0 = 4'h9;
        tick(4);
        in0 = 4'hD;
        tick(12);
        rd(0, 2'd0, 32'hD, 1'b1, "pulse4_data");
        rd(0, 2'd3, 32'h4, 1'b1, "pulse4_cap");

        // any-edge build: press, clear, release, late mask
        in1 = 4'hE;
        tick(8);
        rd(1, 2'd0, 32'hE, 1'b0, "any_press_data");
        rd(1, 2'd3, 32'h1, 1'b0, "any_press_cap");
        wr(1, 2'd3, 32'h1);
        rd(1, 2'd3, 32'h0, 1'b0, "any_clr");
        in1 = 4'hF;
        tick(8);
        rd(1, 2'd3, 32'h1, 1'b0, "any_release_cap");
        wr(1, 2'd2, 32'h1);
        rd(1, 2'd3, 32'h1, 1'b1, "any_mask_on");
        rd(1, 2'd2, 32'h1, 1'b1, "any_mask_rd");
        wr(1, 2'd2, 32'h0);
        rd(1, 2'd3, 32'h1, 1'b0, "any_mask_off");

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
